mem_bus_if: RTL

- Downstream neighbour of memcontrol. It converts memcontrol's single-cycle read and write requests into Wishbone-classic single transfers toward the memory/peripheral bus.
- It returns read data and the bus_full busy indication to memcontrol.
- It registers every request at acceptance, supports byte selects, and bounds each transfer with a timeout that reports a bus error.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/bus_timeout_ctr.sv | 44 ++++
 rtl/mem_bus_if.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions between memcontrol and the Wishbone-classic bus interface.
// Holds bus FSM state encoding and default bus geometry.
package mem_pkg;

  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } bus_state_t;

  function automatic logic is_request(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-state counter for one bus transfer; expired flags the last allowed cycle.
// Counts only while enabled and holds at the terminal value.
module bus_timeout_ctr
  import mem_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  // next count: clear wins, otherwise advance until the terminal value
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CW{1'b0}};
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/mem_bus_if.sv
// Converts memcontrol single-cycle read/write requests into Wishbone-classic
// single transfers with a bounded wait for ack and a sticky timeout flag.
module mem_bus_if
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] sel_in,
  input  logic                read_req,
  input  logic                write_req,
  output logic [DATA_W-1:0]   data_out,
  output logic                bus_full,
  output logic                done,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i
);

  localparam int SEL_W = DATA_W / 8;

  bus_state_t         state_d, state_q;
  logic [ADDR_W-1:0]  adr_d, adr_q;
  logic [DATA_W-1:0]  dat_d, dat_q;
  logic [SEL_W-1:0]   sel_d, sel_q;
  logic               we_d, we_q;
  logic               cyc_d, cyc_q;
  logic               stb_d, stb_q;
  logic [DATA_W-1:0]  data_out_d, data_out_q;
  logic               bus_full_d, bus_full_q;
  logic               done_d, done_q;
  logic               bus_err_d, bus_err_q;
  logic               ctr_clear;
  logic               ctr_en;
  logic               ctr_expired;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (ctr_expired)
  );

  // transfer FSM next-state and datapath register updates
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    data_out_d = data_out_q;
    bus_err_d  = bus_err_q;
    done_d     = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (is_request(read_req, write_req)) begin
          adr_d     = address_in;
          dat_d     = data_in;
          sel_d     = sel_in;
          we_d      = write_req;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          bus_err_d = 1'b0;
          ctr_clear = 1'b1;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // ack is checked before the timeout so a last-cycle ack still completes
        if (wb_ack_i) begin
          if (!we_q) begin
            data_out_d = wb_dat_i;
          end else begin
            data_out_d = data_out_q;
          end
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          done_d    = 1'b1;
          ctr_clear = 1'b1;
          state_d   = DONE;
        end else if (ctr_expired) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          state_d   = ERR;
        end else begin
          ctr_en  = 1'b1;
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    bus_full_d = (state_d != IDLE);
  end

  // state and registered outputs; reset drops the bus cycle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      adr_q      <= {ADDR_W{1'b0}};
      dat_q      <= {DATA_W{1'b0}};
      sel_q      <= {SEL_W{1'b0}};
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      data_out_q <= {DATA_W{1'b0}};
      bus_full_q <= 1'b0;
      done_q     <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      data_out_q <= data_out_d;
      bus_full_q <= bus_full_d;
      done_q     <= done_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign data_out = data_out_q;
  assign bus_full = bus_full_q;
  assign done     = done_q;
  assign bus_err  = bus_err_q;

endmodule
